// File: rtl/jelly_wishbone_sequencer.sv
// rtl/jelly_wishbone_sequencer.sv - command-stream driven Wishbone classic master
// Executes WRITE/READ/POLL/WAIT commands with ack timeout and sticky error flags.
module jelly_wishbone_sequencer #(
  parameter int WB_ADR_WIDTH  = 30,
  parameter int WB_DAT_WIDTH  = 64,
  parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter int ACK_TIMEOUT   = 1024,
  parameter int POLL_INTERVAL = 16,
  parameter int POLL_MAX      = 256,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                    aresetn,
  input  logic                    aclk,
  input  logic [2:0]              s_cmd_op,
  input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
  input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_mask,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  output logic [WB_DAT_WIDTH-1:0] m_rdat_data,
  output logic                    m_rdat_valid,
  input  logic                    m_rdat_ready,
  output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
  output logic                    wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_poll,
  input  logic                    err_clear
);

  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_POLL  = 3'd3;
  localparam logic [2:0] OP_WAIT  = 3'd4;

  localparam int TO_WIDTH = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_WIDTH-1:0]    TO_LIMIT   = TO_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] POLL_GAP   = (POLL_INTERVAL < 1) ? COUNT_WIDTH'(1) : COUNT_WIDTH'(POLL_INTERVAL);
  localparam logic [COUNT_WIDTH-1:0] POLL_LIMIT = COUNT_WIDTH'(POLL_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RDOUT, ST_DELAY} state_t;

  state_t                  state;
  logic [2:0]              cmd_op;
  logic [WB_DAT_WIDTH-1:0] cmd_dat;
  logic [WB_DAT_WIDTH-1:0] cmd_mask;
  logic [COUNT_WIDTH-1:0]  delay_cnt;
  logic [COUNT_WIDTH-1:0]  poll_cnt;
  logic [TO_WIDTH-1:0]     to_cnt;
  logic                    poll_match;
  logic                    poll_last;
  logic                    to_hit;

  assign poll_match = ((wb_dat_i ^ cmd_dat) & cmd_mask) == '0;
  assign poll_last  = (poll_cnt + 1'b1) == POLL_LIMIT;
  assign to_hit     = (ACK_TIMEOUT > 0) && (to_cnt == TO_LIMIT);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      s_cmd_ready  <= 1'b0;
      cmd_op       <= '0;
      cmd_dat      <= '0;
      cmd_mask     <= '0;
      delay_cnt    <= '0;
      poll_cnt     <= '0;
      to_cnt       <= '0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_stb_o     <= 1'b0;
      m_rdat_data  <= '0;
      m_rdat_valid <= 1'b0;
      err_timeout  <= 1'b0;
      err_poll     <= 1'b0;
    end else begin
      // clear first so that an error raised below in the same cycle wins
      if (err_clear) begin
        err_timeout <= 1'b0;
        err_poll    <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          s_cmd_ready <= 1'b1;
          if (s_cmd_valid && s_cmd_ready) begin
            cmd_op   <= s_cmd_op;
            cmd_dat  <= s_cmd_dat;
            cmd_mask <= s_cmd_mask;
            poll_cnt <= '0;
            to_cnt   <= '0;
            case (s_cmd_op)
              OP_WRITE, OP_READ, OP_POLL: begin
                state       <= ST_BUS;
                busy        <= 1'b1;
                s_cmd_ready <= 1'b0;
                wb_adr_o    <= s_cmd_adr;
                wb_dat_o    <= s_cmd_dat;
                wb_sel_o    <= (s_cmd_op == OP_WRITE) ? s_cmd_sel : '1;
                wb_we_o     <= (s_cmd_op == OP_WRITE);
                wb_stb_o    <= 1'b1;
              end
              OP_WAIT: begin
                state       <= ST_DELAY;
                busy        <= 1'b1;
                s_cmd_ready <= 1'b0;
                delay_cnt   <= (s_cmd_dat[COUNT_WIDTH-1:0] == '0) ? COUNT_WIDTH'(1)
                                                                  : s_cmd_dat[COUNT_WIDTH-1:0];
              end
              default: ;
            endcase
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            to_cnt   <= '0;
            if (cmd_op == OP_READ) begin
              m_rdat_data  <= wb_dat_i;
              m_rdat_valid <= 1'b1;
              state        <= ST_RDOUT;
            end else if (cmd_op == OP_POLL && !poll_match) begin
              poll_cnt <= poll_cnt + 1'b1;
              if (poll_last) begin
                err_poll    <= 1'b1;
                state       <= ST_IDLE;
                busy        <= 1'b0;
                s_cmd_ready <= 1'b1;
              end else begin
                delay_cnt <= POLL_GAP;
                state     <= ST_DELAY;
              end
            end else begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              s_cmd_ready <= 1'b1;
            end
          end else if (to_hit) begin
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
            s_cmd_ready <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RDOUT: begin
          if (m_rdat_ready) begin
            m_rdat_valid <= 1'b0;
            state        <= ST_IDLE;
            busy         <= 1'b0;
            s_cmd_ready  <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (delay_cnt <= COUNT_WIDTH'(1)) begin
            if (cmd_op == OP_POLL) begin
              state    <= ST_BUS;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
            end else begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              s_cmd_ready <= 1'b1;
            end
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          s_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jelly_wishbone_sequencer.sv
// tb/tb_jelly_wishbone_sequencer.sv - self-checking bench for jelly_wishbone_sequencer
// Wishbone slave with memory, result-stream backpressure and a command-level model.
module tb_jelly_wishbone_sequencer;
  localparam int AW = 30;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [2:0]    s_cmd_op = '0;
  logic [AW-1:0] s_cmd_adr = '0;
  logic [DW-1:0] s_cmd_dat = '0;
  logic [SW-1:0] s_cmd_sel = '0;
  logic [DW-1:0] s_cmd_mask = '0;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [DW-1:0] m_rdat_data;
  logic          m_rdat_valid;
  logic          m_rdat_ready = 1'b1;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_stb_o;
  logic          wb_ack_i = 1'b0;
  logic          busy;
  logic          err_timeout;
  logic          err_poll;
  logic          err_clear = 1'b0;

  jelly_wishbone_sequencer #(
    .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW),
    .ACK_TIMEOUT(8), .POLL_INTERVAL(16), .POLL_MAX(4), .COUNT_WIDTH(16)
  ) dut (
    .aresetn(aresetn), .aclk(aclk),
    .s_cmd_op(s_cmd_op), .s_cmd_adr(s_cmd_adr), .s_cmd_dat(s_cmd_dat),
    .s_cmd_sel(s_cmd_sel), .s_cmd_mask(s_cmd_mask), .s_cmd_valid(s_cmd_valid),
    .s_cmd_ready(s_cmd_ready),
    .m_rdat_data(m_rdat_data), .m_rdat_valid(m_rdat_valid), .m_rdat_ready(m_rdat_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .busy(busy), .err_timeout(err_timeout), .err_poll(err_poll), .err_clear(err_clear)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
  endtask

  // slave: ack on the slave_lat-th strobe cycle (0 = never), data from rd_q or memory
  int            slave_lat = 1;
  bit            rand_lat = 1'b0;
  int            stb_cyc = 0;
  int            cur_lat = 1;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];

  always @(negedge aclk) begin
    if (wb_stb_o) begin
      stb_cyc++;
      if (stb_cyc == 1) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : slave_lat;
      wb_ack_i = (cur_lat != 0) && (stb_cyc == cur_lat);
      if (wb_ack_i && !wb_we_o) begin
        if (rd_q.size() > 0) wb_dat_i = rd_q.pop_front();
        else wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : '0;
      end
    end else begin
      stb_cyc  = 0;
      wb_ack_i = 1'b0;
    end
  end

  // result consumer: holds ready low for the first hold_n valid cycles
  int hold_n = 0;
  bit rand_bp = 1'b0;
  int vcnt = 0;
  always @(negedge aclk) begin
    vcnt = m_rdat_valid ? vcnt + 1 : 0;
    if (m_rdat_valid && vcnt <= hold_n) m_rdat_ready = 1'b0;
    else m_rdat_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // bus / stream monitor
  int            cyc = 0;
  logic [AW-1:0] tx_adr[$];
  logic [DW-1:0] tx_dat[$];
  logic [SW-1:0] tx_sel[$];
  logic          tx_we[$];
  int            tx_cyc[$];
  logic [DW-1:0] rdat_log[$];
  int            stb_total = 0, stab_err = 0, we_err = 0, rdv_cycles = 0, rdv_ready_err = 0;
  logic          prev_stb = 1'b0;
  logic [AW-1:0] h_adr;
  logic [DW-1:0] h_dat;
  logic [SW-1:0] h_sel;
  logic          h_we;
  logic [DW-1:0] mw;

  always @(posedge aclk) begin
    cyc++;
    if (wb_stb_o) begin
      stb_total++;
      if (prev_stb && (wb_adr_o !== h_adr || wb_dat_o !== h_dat || wb_sel_o !== h_sel || wb_we_o !== h_we))
        stab_err++;
      h_adr = wb_adr_o; h_dat = wb_dat_o; h_sel = wb_sel_o; h_we = wb_we_o;
      if (wb_ack_i) begin
        tx_adr.push_back(wb_adr_o); tx_dat.push_back(wb_dat_o);
        tx_sel.push_back(wb_sel_o); tx_we.push_back(wb_we_o); tx_cyc.push_back(cyc);
        if (wb_we_o) begin
          mw = mem.exists(wb_adr_o) ? mem[wb_adr_o] : '0;
          for (int b = 0; b < SW; b++) if (wb_sel_o[b]) mw[b*8 +: 8] = wb_dat_o[b*8 +: 8];
          mem[wb_adr_o] = mw;
        end
      end
    end else if (wb_we_o) begin
      we_err++;
    end
    prev_stb = wb_stb_o && !wb_ack_i;
    if (m_rdat_valid) begin
      rdv_cycles++;
      if (s_cmd_ready) rdv_ready_err++;
      if (m_rdat_ready) rdat_log.push_back(m_rdat_data);
    end
  end

  task automatic send(input logic [2:0] op, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input logic [DW-1:0] mask);
    int n = 0;
    @(negedge aclk);
    s_cmd_op = op; s_cmd_adr = adr; s_cmd_dat = dat; s_cmd_sel = sel; s_cmd_mask = mask;
    s_cmd_valid = 1'b1;
    while (!s_cmd_ready && n < 1000) begin @(negedge aclk); n++; end
    if (n >= 1000) begin
      n_checks++;
      $display("FAIL send_accept: got ready=0 for 1000 cycles required 1");
    end
    @(posedge aclk);
    #1 s_cmd_valid = 1'b0;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    while (1) begin
      @(negedge aclk);
      if (!busy || n > 2000) break;
      n++;
    end
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [DW-1:0] mask;
    int            lat;
    logic [DW-1:0] rdata;
    int            exp_busy;
    int            exp_tx;
    logic          exp_we;
    logic [SW-1:0] exp_sel;
    int            exp_rd;
  } vec_t;

  vec_t          vecs[11];
  int            nb, t0, r0, s0, rv0, e0, n, nbus;
  logic [DW-1:0] exp_mem[logic [AW-1:0]];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] md, rdat;
  logic [AW-1:0] radr;
  logic [SW-1:0] rsel;
  logic [2:0]    rop;
  int            rr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd1, 30'h20000, 64'h3, 8'hff, 64'h0, 2, 64'h0, 2, 1, 1'b1, 8'hff, 0};
    vecs[1]  = '{3'd1, 30'h155, 64'hdeadbeefcafef00d, 8'h0f, 64'h0, 1, 64'h0, 1, 1, 1'b1, 8'h0f, 0};
    vecs[2]  = '{3'd2, 30'h20000, 64'h0, 8'h00, 64'h0, 3, 64'h1234, 4, 1, 1'b0, 8'hff, 1};
    vecs[3]  = '{3'd3, 30'h40, 64'h55, 8'h00, 64'h0, 1, 64'haa, 1, 1, 1'b0, 8'hff, 0};
    vecs[4]  = '{3'd3, 30'h44, 64'h1200, 8'h00, 64'hff00, 2, 64'h12ab, 2, 1, 1'b0, 8'hff, 0};
    vecs[5]  = '{3'd4, 30'h0, 64'h0, 8'h00, 64'h0, 1, 64'h0, 1, 0, 1'b0, 8'h00, 0};
    vecs[6]  = '{3'd4, 30'h0, 64'd10, 8'h00, 64'h0, 1, 64'h0, 10, 0, 1'b0, 8'h00, 0};
    vecs[7]  = '{3'd4, 30'h0, 64'h10003, 8'h00, 64'h0, 1, 64'h0, 3, 0, 1'b0, 8'h00, 0};
    vecs[8]  = '{3'd5, 30'h77, 64'h9, 8'hff, 64'h0, 1, 64'h0, 0, 0, 1'b0, 8'h00, 0};
    vecs[9]  = '{3'd0, 30'h78, 64'h9, 8'hff, 64'h0, 1, 64'h0, 0, 0, 1'b0, 8'h00, 0};
    vecs[10] = '{3'd7, 30'h79, 64'h5, 8'hff, 64'h0, 1, 64'h0, 0, 0, 1'b0, 8'h00, 0};

    repeat (3) @(negedge aclk);
    check("rst_ready", s_cmd_ready, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_timeout, err_poll}, 0);
    check("rst_rdat", {m_rdat_valid, m_rdat_data}, 0);
    check("rst_adr", wb_adr_o, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      t0 = tx_adr.size();
      r0 = rdat_log.size();
      slave_lat = vecs[i].lat;
      rd_q.delete();
      if (vecs[i].op == 3'd2 || vecs[i].op == 3'd3) rd_q.push_back(vecs[i].rdata);
      send(vecs[i].op, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].mask);
      busy_cycles(nb);
      check($sformatf("v%0d_busy", i), nb, vecs[i].exp_busy);
      check($sformatf("v%0d_ready", i), s_cmd_ready, 1);
      check($sformatf("v%0d_ntx", i), tx_adr.size() - t0, vecs[i].exp_tx);
      if (vecs[i].exp_tx > 0 && tx_adr.size() > t0) begin
        check($sformatf("v%0d_adr", i), tx_adr[$], vecs[i].adr);
        check($sformatf("v%0d_we", i), tx_we[$], vecs[i].exp_we);
        check($sformatf("v%0d_sel", i), tx_sel[$], vecs[i].exp_sel);
        if (vecs[i].exp_we) check($sformatf("v%0d_dat", i), tx_dat[$], vecs[i].dat);
      end
      check($sformatf("v%0d_nrd", i), rdat_log.size() - r0, vecs[i].exp_rd);
      if (vecs[i].exp_rd > 0) check($sformatf("v%0d_rdat", i), rdat_log[$], vecs[i].rdata);
      check($sformatf("v%0d_errs", i), {err_timeout, err_poll}, 0);
    end

    // read result held under backpressure
    hold_n = 5; slave_lat = 1; rd_q.push_back(64'h1234);
    rv0 = rdv_cycles; e0 = rdv_ready_err; r0 = rdat_log.size();
    send(3'd2, 30'h20000, 64'h0, 8'h00, 64'h0);
    busy_cycles(nb);
    hold_n = 0;
    check("rdbp_busy", nb, 7);
    check("rdbp_valid_cycles", rdv_cycles - rv0, 6);
    check("rdbp_ready_during_valid", rdv_ready_err - e0, 0);
    check("rdbp_count", rdat_log.size() - r0, 1);
    check("rdbp_data", rdat_log[$], 64'h1234);

    // poll that matches on the third read
    rd_q.delete(); rd_q.push_back(64'h0); rd_q.push_back(64'h0); rd_q.push_back(64'h1);
    t0 = tx_cyc.size();
    send(3'd3, 30'h300, 64'h1, 8'h00, 64'h1);
    busy_cycles(nb);
    check("poll3_reads", tx_cyc.size() - t0, 3);
    if (tx_cyc.size() - t0 == 3) begin
      check("poll3_gap1", tx_cyc[t0+1] - tx_cyc[t0], 17);
      check("poll3_gap2", tx_cyc[t0+2] - tx_cyc[t0+1], 17);
    end
    check("poll3_busy", nb, 35);
    check("poll3_err", err_poll, 0);

    // poll that never matches
    t0 = tx_cyc.size();
    send(3'd3, 30'h304, 64'h1, 8'h00, 64'h1);
    busy_cycles(nb);
    check("pollx_reads", tx_cyc.size() - t0, 4);
    check("pollx_busy", nb, 52);
    check("pollx_err_poll", err_poll, 1);
    check("pollx_err_timeout", err_timeout, 0);
    @(negedge aclk) err_clear = 1'b1;
    @(negedge aclk) err_clear = 1'b0;
    check("pollx_cleared", err_poll, 0);

    // clear coincident with the error being raised
    t0 = tx_cyc.size();
    send(3'd3, 30'h304, 64'h1, 8'h00, 64'h1);
    n = 0;
    while (!(wb_stb_o && tx_cyc.size() - t0 == 3) && n < 500) begin @(negedge aclk); n++; end
    check("pollc_reached_last", n < 500, 1);
    err_clear = 1'b1;
    @(posedge aclk);
    #1 err_clear = 1'b0;
    @(negedge aclk);
    check("pollc_set_wins", err_poll, 1);
    busy_cycles(nb);
    @(negedge aclk) err_clear = 1'b1;
    @(negedge aclk) err_clear = 1'b0;

    // ack timeouts
    slave_lat = 0; s0 = stb_total;
    send(3'd1, 30'h500, 64'habc, 8'hff, 64'h0);
    busy_cycles(nb);
    check("to_stb_cycles", stb_total - s0, 8);
    check("to_busy", nb, 8);
    check("to_err", err_timeout, 1);
    r0 = rdat_log.size(); rv0 = rdv_cycles;
    send(3'd2, 30'h501, 64'h0, 8'h00, 64'h0);
    busy_cycles(nb);
    check("to_rd_no_result", rdat_log.size() - r0, 0);
    check("to_rd_no_valid", rdv_cycles - rv0, 0);
    check("to_err_sticky", err_timeout, 1);
    slave_lat = 1; t0 = tx_adr.size();
    send(3'd1, 30'h502, 64'h77, 8'h01, 64'h0);
    busy_cycles(nb);
    check("to_next_ntx", tx_adr.size() - t0, 1);
    check("to_next_adr", tx_adr[$], 30'h502);
    @(negedge aclk) err_clear = 1'b1;
    @(negedge aclk) err_clear = 1'b0;
    check("to_cleared", err_timeout, 0);

    // reset while strobing
    slave_lat = 0;
    send(3'd1, 30'h600, 64'h99, 8'hff, 64'h0);
    repeat (3) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("rstbus_stb", wb_stb_o, 0);
    check("rstbus_busy", busy, 0);
    check("rstbus_ready", s_cmd_ready, 0);
    @(negedge aclk) aresetn = 1'b1;

    // reset while a read result is pending
    slave_lat = 1; hold_n = 100; r0 = rdat_log.size();
    send(3'd2, 30'h20000, 64'h0, 8'h00, 64'h0);
    repeat (3) @(negedge aclk);
    check("rstrd_valid_before", m_rdat_valid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rstrd_valid", m_rdat_valid, 0);
    check("rstrd_data", m_rdat_data, 0);
    @(negedge aclk) aresetn = 1'b1;
    hold_n = 0;
    check("rstrd_no_result", rdat_log.size() - r0, 0);

    slave_lat = 2; t0 = tx_adr.size();
    send(3'd1, 30'h601, 64'h5a5a, 8'h3c, 64'h0);
    busy_cycles(nb);
    check("rstw_busy", nb, 2);
    check("rstw_ntx", tx_adr.size() - t0, 1);
    check("rstw_adr", tx_adr[$], 30'h601);
    check("rstw_dat", tx_dat[$], 64'h5a5a);
    check("rstw_sel", tx_sel[$], 8'h3c);

    // random command stream against a memory model
    rand_lat = 1'b1; rand_bp = 1'b1; rd_q.delete();
    t0 = tx_adr.size(); r0 = rdat_log.size(); nbus = 0;
    for (int k = 0; k < 40; k++) begin
      rr   = int'($urandom_range(0, 3));
      rop  = (rr == 3) ? 3'd4 : 3'(rr);
      radr = 30'h1000 + 30'($urandom_range(0, 7));
      rdat = {$urandom, $urandom};
      rsel = 8'($urandom);
      if (rop == 3'd4) rdat = 64'($urandom_range(0, 3));
      if (rop == 3'd1) begin
        md = exp_mem.exists(radr) ? exp_mem[radr] : '0;
        for (int b = 0; b < SW; b++) if (rsel[b]) md[b*8 +: 8] = rdat[b*8 +: 8];
        exp_mem[radr] = md;
        nbus++;
      end else if (rop == 3'd2) begin
        exp_rd.push_back(exp_mem.exists(radr) ? exp_mem[radr] : '0);
        nbus++;
      end
      send(rop, radr, rdat, rsel, 64'h0);
    end
    busy_cycles(nb);
    check("rnd_ntx", tx_adr.size() - t0, nbus);
    check("rnd_nrd", rdat_log.size() - r0, exp_rd.size());
    for (int k = 0; k < exp_rd.size(); k++)
      if (r0 + k < rdat_log.size()) check($sformatf("rnd_rd%0d", k), rdat_log[r0+k], exp_rd[k]);
    check("rnd_errs", {err_timeout, err_poll}, 0);

    check("stb_fields_stable", stab_err, 0);
    check("we_low_without_stb", we_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
